// File: rtl/cache_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module : cache_mem_bridge_pkg
// Brief  : Shared cache/memory structure definitions for the cache-to-memory
//          bridge. Holds the word/block geometry, the cache-side request and
//          response structs, the bridge state encoding and the watchdog limit.
//          Optional feature macro used by the bridge: CACHE_MEM_BRIDGE_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
package cache_mem_bridge_pkg;

    parameter int ADDR_WIDTH         = 12;
    parameter int DATA_WIDTH         = 32;
    parameter int BLOCK_SIZE         = 8;
    parameter int OFFSET_WIDTH       = 3;
    // Beat counters must be able to hold BLOCK_SIZE itself, not just the last index.
    parameter int BEAT_WIDTH         = OFFSET_WIDTH + 1;
    parameter int MEM_TIMEOUT_CYCLES = 64;

    typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] block_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  cs;
        logic                  rw;     // 1 = write-back, 0 = allocate read
        block_t                data;
    } memory_request_t;

    typedef struct packed {
        logic   ack;
        block_t data;
    } memory_response_t;

    typedef enum logic [1:0] {
        br_idle     = 2'd0,
        br_wr_burst = 2'd1,
        br_rd_burst = 2'd2,
        br_ack      = 2'd3
    } bridge_state_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_bridge_watchdog.sv
`default_nettype none
// ============================================================================
// Module : mem_bridge_watchdog
// Brief  : Counts consecutive stalled cycles (active with no progress) and
//          flags expiry on the LIMIT-th such cycle. Any progress or leaving the
//          active window restarts the count.
// Ports  : clk, rst_n (async active-low)
//          active   - bridge is inside a burst
//          progress - a grant or an accepted read return happened this cycle
//          expired  - this cycle is the LIMIT-th consecutive stalled cycle
// Rev    : 1.0  initial release
// ============================================================================
module mem_bridge_watchdog
    import cache_mem_bridge_pkg::*;
#(
    parameter int LIMIT = MEM_TIMEOUT_CYCLES
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic progress,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;
    logic             w_stalled;

    assign w_stalled = active && !progress;
    assign expired   = w_stalled && (r_count == CNT_W'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_stalled && !expired) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : cache_mem_bridge
// Brief  : Serialises one cache block transfer into BLOCK_SIZE word beats on a
//          req/gnt/rvalid memory port. Cache side uses a four-phase cs/ack
//          handshake; reads gather the block and return it on mem_resp.data.
//          Optional feature macro: CACHE_MEM_BRIDGE_TIMEOUT_EN (stall watchdog
//          driving a sticky err and force-completing the burst).
// Ports  : clk, rst_n (async active-low)
//          mem_req  / mem_resp            - cache-side block request/response
//          wm_req, wm_we, wm_addr, wm_wdata - beat issue to memory
//          wm_gnt                         - beat accepted when wm_req & wm_gnt
//          wm_rvalid, wm_rdata            - in-order read returns
//          err                            - sticky timeout flag (0 if no watchdog)
// Rev    : 1.0  initial release
// ============================================================================
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  memory_request_t       mem_req,
    output memory_response_t      mem_resp,
    output logic                  wm_req,
    output logic                  wm_we,
    output logic [ADDR_WIDTH-1:0] wm_addr,
    output logic [DATA_WIDTH-1:0] wm_wdata,
    input  logic                  wm_gnt,
    input  logic                  wm_rvalid,
    input  logic [DATA_WIDTH-1:0] wm_rdata,
    output logic                  err
);

    bridge_state_t r_state;
    bridge_state_t w_state_nxt;

    logic [ADDR_WIDTH-OFFSET_WIDTH-1:0] r_base;
    block_t                             r_wbuf;
    block_t                             r_rbuf;
    logic [BEAT_WIDTH-1:0]              r_issue_cnt;
    logic [BEAT_WIDTH-1:0]              r_ret_cnt;

    logic w_in_burst;
    logic w_issue_pending;
    logic w_grant;
    logic w_ret;
    logic w_last_grant;
    logic w_last_ret;
    logic w_timeout;
    logic w_unused_offset;

    // The request's offset bits never matter: every transfer is block aligned.
    assign w_unused_offset = &{1'b0, mem_req.addr[OFFSET_WIDTH-1:0]};

    assign w_in_burst      = (r_state == br_wr_burst) || (r_state == br_rd_burst);
    assign w_issue_pending = w_in_burst && (r_issue_cnt < BEAT_WIDTH'(BLOCK_SIZE));
    assign w_grant         = w_issue_pending && wm_gnt;
    // Returns are only meaningful during a read burst and only until the block is full.
    assign w_ret           = (r_state == br_rd_burst) && wm_rvalid &&
                             (r_ret_cnt < BEAT_WIDTH'(BLOCK_SIZE));
    assign w_last_grant    = w_grant && (r_issue_cnt == BEAT_WIDTH'(BLOCK_SIZE - 1));
    assign w_last_ret      = w_ret && (r_ret_cnt == BEAT_WIDTH'(BLOCK_SIZE - 1));

`ifdef CACHE_MEM_BRIDGE_TIMEOUT_EN
    logic w_progress;
    logic r_err;

    assign w_progress = w_grant || w_ret;

    mem_bridge_watchdog #(
        .LIMIT    (MEM_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active   (w_in_burst),
        .progress (w_progress),
        .expired  (w_timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= br_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs. Outputs are decoded from registered state so
    // they return to reset values the moment rst_n is asserted.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        wm_req        = w_issue_pending;
        wm_we         = (r_state == br_wr_burst);
        wm_addr       = {r_base, r_issue_cnt[OFFSET_WIDTH-1:0]};
        wm_wdata      = r_wbuf[r_issue_cnt[OFFSET_WIDTH-1:0]];
        mem_resp.ack  = (r_state == br_ack);
        mem_resp.data = r_rbuf;

        case (r_state)
            br_idle: begin
                if (mem_req.cs) begin
                    w_state_nxt = mem_req.rw ? br_wr_burst : br_rd_burst;
                end
            end
            br_wr_burst: begin
                if (w_last_grant || w_timeout) begin
                    w_state_nxt = br_ack;
                end
            end
            br_rd_burst: begin
                // The last return may coincide with or trail the last grant;
                // completion is keyed on returns only.
                if (w_last_ret || w_timeout) begin
                    w_state_nxt = br_ack;
                end
            end
            br_ack: begin
                if (!mem_req.cs) begin
                    w_state_nxt = br_idle;
                end
            end
            default: begin
                w_state_nxt = br_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, beat counters and read gather buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_wbuf      <= '0;
            r_rbuf      <= '0;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
        end else begin
            if ((r_state == br_idle) && mem_req.cs) begin
                r_base      <= mem_req.addr[ADDR_WIDTH-1:OFFSET_WIDTH];
                r_wbuf      <= mem_req.data;
                r_issue_cnt <= '0;
                r_ret_cnt   <= '0;
            end else begin
                if (w_grant) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_ret) begin
                    r_rbuf[r_ret_cnt[OFFSET_WIDTH-1:0]] <= wm_rdata;
                    r_ret_cnt                           <= r_ret_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_cache_mem_bridge
// Brief  : Self-checking bench for cache_mem_bridge. A table of block
//          transfers is applied in a loop; hand-written sequences cover the
//          handshake hold, cs drop mid-burst, reset mid-burst and the stall
//          watchdog (CACHE_MEM_BRIDGE_TIMEOUT_EN).
// Rev    : 1.0  initial release
// ============================================================================
module tb_cache_mem_bridge;
    import cache_mem_bridge_pkg::*;

    logic                  clk   = 1'b0;
    logic                  rst_n = 1'b0;
    memory_request_t       mem_req;
    memory_response_t      mem_resp;
    logic                  wm_req;
    logic                  wm_we;
    logic [ADDR_WIDTH-1:0] wm_addr;
    logic [DATA_WIDTH-1:0] wm_wdata;
    logic                  wm_gnt    = 1'b1;
    logic                  wm_rvalid = 1'b0;
    logic [DATA_WIDTH-1:0] wm_rdata  = '0;
    logic                  err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    cache_mem_bridge dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_req   (mem_req),
        .mem_resp  (mem_resp),
        .wm_req    (wm_req),
        .wm_we     (wm_we),
        .wm_addr   (wm_addr),
        .wm_wdata  (wm_wdata),
        .wm_gnt    (wm_gnt),
        .wm_rvalid (wm_rvalid),
        .wm_rdata  (wm_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        int                    due;
    } pend_t;

    typedef struct {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } beat_t;

    pend_t  pend[$];
    beat_t  beats[$];
    int     rd_lat      = 1;
    logic   gnt_default = 1'b1;
    logic [BLOCK_SIZE-1:0] stall_mask = '0;
    logic [BLOCK_SIZE-1:0] stall_done = '0;
    int     stall_left  = 0;
    logic   prev_stall  = 1'b0;
    logic [ADDR_WIDTH-1:0] prev_addr  = '0;
    logic [DATA_WIDTH-1:0] prev_wdata = '0;

    // Beat log and stall-stability monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && wm_req) begin
                check("stall_addr_hold", 64'(wm_addr), 64'(prev_addr));
                check("stall_wdata_hold", 64'(wm_wdata), 64'(prev_wdata));
            end
            prev_stall = wm_req && !wm_gnt;
            prev_addr  = wm_addr;
            prev_wdata = wm_wdata;
            if (wm_req && wm_gnt) begin
                beats.push_back('{wm_we, wm_addr, wm_wdata});
                if (!wm_we) pend.push_back('{wm_addr, cyc + rd_lat});
            end
        end
    end

    // Drives gnt/rvalid for the new cycle just after each rising edge.
    always @(posedge clk) begin
        #1;
        wm_rvalid = 1'b0;
        wm_rdata  = '0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            wm_rvalid = 1'b1;
            wm_rdata  = 32'hC0DE_0000 | 32'(pend[0].addr);
            pend.delete(0);
        end
        if (stall_left == 0 && wm_req && stall_mask[wm_addr[OFFSET_WIDTH-1:0]] &&
            !stall_done[wm_addr[OFFSET_WIDTH-1:0]]) begin
            stall_left = 3;
            stall_done[wm_addr[OFFSET_WIDTH-1:0]] = 1'b1;
        end
        if (stall_left > 0) begin
            wm_gnt = 1'b0;
            stall_left--;
        end else begin
            wm_gnt = gnt_default;
        end
    end

    // ---------------- stimulus helpers ----------------
    typedef struct {
        logic                  rw;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dbase;
        int                    lat;
        logic [BLOCK_SIZE-1:0] smask;
        int                    hold;     // extra cycles cs stays high after ack
        logic [ADDR_WIDTH-1:0] base;     // expected aligned base
        int                    ack_lat;  // expected cycles from cs sample to ack
    } vec_t;

    block_t exp_rbuf = '0;

    task automatic start_req(input logic rw, input logic [ADDR_WIDTH-1:0] addr,
                             input logic [DATA_WIDTH-1:0] dbase, output int t0);
        @(posedge clk); #1;
        mem_req.addr = addr;
        mem_req.rw   = rw;
        mem_req.cs   = 1'b1;
        for (int i = 0; i < BLOCK_SIZE; i++) mem_req.data[i] = dbase + DATA_WIDTH'(i);
        t0 = cyc;
    endtask

    task automatic wait_ack(input int limit, output int t_ack, output logic ok);
        ok    = 1'b0;
        t_ack = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (mem_resp.ack) begin
                ok    = 1'b1;
                t_ack = cyc;
                break;
            end
        end
    endtask

    task automatic release_cs(input string tag);
        @(posedge clk); #1;
        mem_req.cs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("%s_ack_drop", tag), 64'(mem_resp.ack), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n      = 1'b0;
        mem_req.cs = 1'b0;
        pend.delete();
        stall_mask  = '0;
        stall_done  = '0;
        stall_left  = 0;
        gnt_default = 1'b1;
        exp_rbuf    = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   t0;
        int   ta;
        logic ok;
        beats.delete();
        rd_lat     = v.lat;
        stall_mask = v.smask;
        stall_done = '0;
        start_req(v.rw, v.addr, v.dbase, t0);
        wait_ack(300, ta, ok);
        check($sformatf("%s_ack_seen", tag), 64'(ok), 64'd1);
        if (ok) check($sformatf("%s_ack_latency", tag), 64'(ta - t0), 64'(v.ack_lat));
        check($sformatf("%s_beat_count", tag), 64'(beats.size()), 64'(BLOCK_SIZE));
        for (int i = 0; i < BLOCK_SIZE && i < beats.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(beats[i].addr), 64'(v.base + ADDR_WIDTH'(i)));
            check($sformatf("%s_we%0d", tag, i), 64'(beats[i].we), 64'(v.rw));
            if (v.rw) check($sformatf("%s_wdata%0d", tag, i), 64'(beats[i].wdata),
                            64'(v.dbase + DATA_WIDTH'(i)));
        end
        if (!v.rw) begin
            for (int i = 0; i < BLOCK_SIZE; i++)
                exp_rbuf[i] = 32'hC0DE_0000 | 32'(v.base + ADDR_WIDTH'(i));
        end
        for (int i = 0; i < BLOCK_SIZE; i++)
            check($sformatf("%s_resp%0d", tag, i), 64'(mem_resp.data[i]), 64'(exp_rbuf[i]));
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("%s_hold_ack", tag), 64'(mem_resp.ack), 64'd1);
            check($sformatf("%s_hold_noreq", tag), 64'(wm_req), 64'd0);
        end
        release_cs(tag);
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[5];

    initial begin
        int   t0;
        int   ta;
        int   acks;
        logic ok;

        vecs[0] = '{1'b1, 12'h0A5, 32'h0000_1000, 1, 8'h00, 0, 12'h0A0, 9};
        vecs[1] = '{1'b0, 12'h3F8, 32'h0,         1, 8'h00, 0, 12'h3F8, 10};
        vecs[2] = '{1'b0, 12'h7FF, 32'h0,         4, 8'h24, 0, 12'h7F8, 19};
        vecs[3] = '{1'b1, 12'hFFF, 32'hA5A5_0000, 1, 8'h01, 5, 12'hFF8, 12};
        vecs[4] = '{1'b0, 12'h000, 32'h0,         3, 8'h00, 0, 12'h000, 12};

        mem_req = '0;
        @(negedge clk);
        check("rst_ack", 64'(mem_resp.ack), 64'd0);
        check("rst_data", 64'(|mem_resp.data), 64'd0);
        check("rst_req", 64'(wm_req), 64'd0);
        check("rst_we", 64'(wm_we), 64'd0);
        check("rst_addr", 64'(wm_addr), 64'd0);
        check("rst_wdata", 64'(wm_wdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k], $sformatf("v%0d", k));

        // After the handshake-hold write, a fresh read must start from idle.
        run_vec('{1'b0, 12'h5A3, 32'h0, 2, 8'h00, 0, 12'h5A0, 11}, "after_hold");

        // cs dropped and request scrambled mid-burst: original burst completes,
        // ack lasts a single cycle, nothing restarts.
        beats.delete();
        rd_lat = 1;
        start_req(1'b1, 12'h055, 32'h0000_2000, t0);
        repeat (3) @(posedge clk);
        #1;
        mem_req.cs   = 1'b0;
        mem_req.rw   = 1'b0;
        mem_req.addr = 12'h7F0;
        for (int i = 0; i < BLOCK_SIZE; i++) mem_req.data[i] = 32'hDEAD_0000;
        wait_ack(50, ta, ok);
        check("csdrop_ack_seen", 64'(ok), 64'd1);
        check("csdrop_ack_latency", 64'(ta - t0), 64'd9);
        @(negedge clk);
        check("csdrop_ack_one_cycle", 64'(mem_resp.ack), 64'd0);
        @(negedge clk);
        check("csdrop_no_restart", 64'(wm_req), 64'd0);
        check("csdrop_beat_count", 64'(beats.size()), 64'(BLOCK_SIZE));
        for (int i = 0; i < BLOCK_SIZE && i < beats.size(); i++) begin
            check($sformatf("csdrop_addr%0d", i), 64'(beats[i].addr), 64'(12'h050 + 12'(i)));
            check($sformatf("csdrop_wdata%0d", i), 64'(beats[i].wdata), 64'(32'h2000 + 32'(i)));
        end

        // Reset asserted after beat 3 of a write.
        beats.delete();
        start_req(1'b1, 12'h200, 32'h0000_3000, t0);
        for (int n = 0; n < 20 && beats.size() < 4; n++) @(negedge clk);
        check("rstmid_beats_before", 64'(beats.size()), 64'd4);
        @(posedge clk); #1;
        rst_n      = 1'b0;
        mem_req.cs = 1'b0;
        #1;
        check("rstmid_req", 64'(wm_req), 64'd0);
        check("rstmid_ack", 64'(mem_resp.ack), 64'd0);
        check("rstmid_we", 64'(wm_we), 64'd0);
        check("rstmid_addr", 64'(wm_addr), 64'd0);
        check("rstmid_wdata", 64'(wm_wdata), 64'd0);
        check("rstmid_data", 64'(|mem_resp.data), 64'd0);
        pend.delete();
        exp_rbuf = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_vec('{1'b0, 12'h123, 32'h0, 2, 8'h00, 0, 12'h120, 11}, "post_rst");

        // Memory never grants.
        beats.delete();
        gnt_default = 1'b0;
        start_req(1'b0, 12'h400, 32'h0, t0);
`ifdef CACHE_MEM_BRIDGE_TIMEOUT_EN
        wait_ack(200, ta, ok);
        check("wd_ack_seen", 64'(ok), 64'd1);
        check("wd_ack_latency", 64'(ta - t0), 64'(MEM_TIMEOUT_CYCLES + 1));
        check("wd_err_set", 64'(err), 64'd1);
        release_cs("wd");
        repeat (5) @(negedge clk);
        check("wd_err_sticky", 64'(err), 64'd1);
        check("wd_no_beats", 64'(beats.size()), 64'd0);
        do_reset();
        @(negedge clk);
        check("wd_err_cleared", 64'(err), 64'd0);
`else
        acks = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_resp.ack) acks++;
            if (err) acks += 1000;
        end
        check("nowd_no_ack_no_err", 64'(acks), 64'd0);
        check("nowd_still_waiting", 64'(wm_req), 64'd1);
        check("nowd_err", 64'(err), 64'd0);
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout: actual=running required=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
